// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the NPC core, driving the register file's
// single write port.
//
// Two producers hand over completed results on valid/ready handshakes:
// EXU (ALU/jump link values) and LSU (raw 32-bit load words). A round-robin
// arbiter grants at most one producer per cycle. The LSU word is aligned and
// sign/zero-extended. Writes to x0 and misaligned loads are suppressed. The
// chosen write is registered onto rf_*. Every accepted transaction is counted.
//
// Optional macro WB_FORWARD_EN adds a combinational bypass of the write that
// lands this cycle (ports fwd_raddr, fwd_rf_data, fwd_data).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   exu_valid/ready   EXU handshake; exu_rd, exu_data carry the result
//   lsu_valid/ready   LSU handshake; lsu_rd, lsu_rdata, lsu_offset,
//                     lsu_size (00 B, 01 H, 10 W, 11 reserved), lsu_unsigned
//   rf_wen/waddr/wdata registered register-file write port
//   misalign_err      registered one-cycle pulse for a dropped misaligned load
//   retire_cnt        accepted-transaction counter (wraps)
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [1:0]            lsu_offset,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  retire_cnt
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr,
  input  logic [DATA_WIDTH-1:0] fwd_rf_data,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam logic GRANT_EXU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  logic                  last_grant_q;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  conflict;
  logic                  grant_exu, grant_lsu;
  logic                  accept;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] byte_shift, half_shift;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [DATA_WIDTH-1:0] load_val;

  // Arbitration uses only valids and last_grant, so ready never depends on data.
  assign conflict  = exu_valid & lsu_valid;
  assign grant_exu = exu_valid & (~lsu_valid | (last_grant_q == GRANT_LSU));
  assign grant_lsu = lsu_valid & (~exu_valid | (last_grant_q == GRANT_EXU));
  assign exu_ready = ~rst & grant_exu;
  assign lsu_ready = ~rst & grant_lsu;
  assign accept    = exu_ready | lsu_ready;

  assign misaligned = ((lsu_size == SIZE_H) & lsu_offset[0])
                    | ((lsu_size == SIZE_W) & (lsu_offset != 2'b00))
                    | (lsu_size == 2'b11);

  // Shift the selected lane down to bit 0 and then take the low bits.
  assign byte_shift = lsu_rdata >> {lsu_offset, 3'b000};
  assign half_shift = lsu_rdata >> {lsu_offset[1], 4'b0000};
  assign byte_val   = byte_shift[7:0];
  assign half_val   = half_shift[15:0];

  always_comb begin
    load_val = lsu_rdata;
    case (lsu_size)
      SIZE_B:  load_val = {{(DATA_WIDTH-8){~lsu_unsigned & byte_val[7]}}, byte_val};
      SIZE_H:  load_val = {{(DATA_WIDTH-16){~lsu_unsigned & half_val[15]}}, half_val};
      default: load_val = lsu_rdata;
    endcase
  end

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    misalign_d = 1'b0;
    if (lsu_ready) begin
      misalign_d = misaligned;
      if (!misaligned && lsu_rd != '0) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = lsu_rd;
        rf_wdata_d = load_val;
      end
    end else if (exu_ready && exu_rd != '0) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = exu_rd;
      rf_wdata_d = exu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_EXU;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      misalign_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (conflict) begin
        last_grant_q <= grant_lsu ? GRANT_LSU : GRANT_EXU;
      end
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_q + CNT_WIDTH'(accept);
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign misalign_err = misalign_q;
  assign retire_cnt   = cnt_q;

`ifdef WB_FORWARD_EN
  assign fwd_data = (rf_wen_q && (rf_waddr_q == fwd_raddr) && (fwd_raddr != '0))
                    ? rf_wdata_q : fwd_rf_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset state, EXU write, load alignment and
// extension, misaligned loads and x0 suppression, round-robin contention,
// reset mid-stream, and (when WB_FORWARD_EN is defined) the bypass.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_offset, lsu_size;
  logic        lsu_unsigned;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic [31:0] retire_cnt;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_raddr;
  logic [31:0] fwd_rf_data, fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_offset(lsu_offset), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_err(misalign_err), .retire_cnt(retire_cnt)
`ifdef WB_FORWARD_EN
    , .fwd_raddr(fwd_raddr), .fwd_rf_data(fwd_rf_data), .fwd_data(fwd_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] rd, input logic [1:0] size,
                      input logic [1:0] off, input logic uns);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_size = size; lsu_offset = off; lsu_unsigned = uns;
  endtask

  initial begin
    rst = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'hCAFE;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_rdata = 32'h80FF7F01;
    lsu_offset = 2'd0; lsu_size = 2'b10; lsu_unsigned = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_raddr = 5'd0; fwd_rf_data = 32'h0;
`endif
    tick(); tick();
    chk("rst_wen",      32'(rf_wen), 32'd0);
    chk("rst_waddr",    32'(rf_waddr), 32'd0);
    chk("rst_wdata",    rf_wdata, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_cnt",      retire_cnt, 32'd0);
    chk("rst_exu_rdy",  32'(exu_ready), 32'd0);
    chk("rst_lsu_rdy",  32'(lsu_ready), 32'd0);

    // EXU alone
    rst = 1'b0; lsu_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
    #1;
    chk("exu_rdy", 32'(exu_ready), 32'd1);
    chk("exu_lsu_rdy", 32'(lsu_ready), 32'd0);
    tick();
    exu_valid = 1'b0;
    chk("exu_wen",   32'(rf_wen), 32'd1);
    chk("exu_waddr", 32'(rf_waddr), 32'd5);
    chk("exu_wdata", rf_wdata, 32'h1234);
    chk("exu_cnt",   retire_cnt, 32'd1);
    tick();
    chk("idle_wen",   32'(rf_wen), 32'd0);
    chk("idle_waddr", 32'(rf_waddr), 32'd5);
    chk("idle_wdata", rf_wdata, 32'h1234);
    chk("idle_cnt",   retire_cnt, 32'd1);

    // Load alignment / extension on 0x80FF7F01
    load(5'd3, 2'b00, 2'd1, 1'b0);
    #1 chk("ld_rdy", 32'(lsu_ready), 32'd1);
    tick();
    chk("lb1_wen",   32'(rf_wen), 32'd1);
    chk("lb1_waddr", 32'(rf_waddr), 32'd3);
    chk("lb1_wdata", rf_wdata, 32'h0000007F);
    load(5'd3, 2'b00, 2'd2, 1'b0); tick();
    chk("lb2_wdata", rf_wdata, 32'hFFFFFFFF);
    load(5'd3, 2'b01, 2'd2, 1'b1); tick();
    chk("lhu2_wdata", rf_wdata, 32'h000080FF);
    load(5'd3, 2'b01, 2'd2, 1'b0); tick();
    chk("lh2_wdata", rf_wdata, 32'hFFFF80FF);
    load(5'd3, 2'b00, 2'd3, 1'b1); tick();
    chk("lbu3_wdata", rf_wdata, 32'h00000080);
    load(5'd3, 2'b10, 2'd0, 1'b1); tick();
    chk("lw_wdata", rf_wdata, 32'h80FF7F01);
    chk("ld_cnt",   retire_cnt, 32'd7);

    // Misaligned word
    load(5'd4, 2'b10, 2'd2, 1'b0); tick();
    lsu_valid = 1'b0;
    chk("mw_wen",      32'(rf_wen), 32'd0);
    chk("mw_misalign", 32'(misalign_err), 32'd1);
    chk("mw_cnt",      retire_cnt, 32'd8);
    chk("mw_waddr",    32'(rf_waddr), 32'd3);
    chk("mw_wdata",    rf_wdata, 32'h80FF7F01);
    tick();
    chk("mw_pulse_end", 32'(misalign_err), 32'd0);
    // Misaligned half and reserved size
    load(5'd4, 2'b01, 2'd1, 1'b0); tick();
    chk("mh_misalign", 32'(misalign_err), 32'd1);
    chk("mh_wen",      32'(rf_wen), 32'd0);
    load(5'd4, 2'b11, 2'd0, 1'b0); tick();
    lsu_valid = 1'b0;
    chk("mr_misalign", 32'(misalign_err), 32'd1);
    chk("mr_cnt",      retire_cnt, 32'd10);

    // x0 write from EXU
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hAA; tick();
    exu_valid = 1'b0;
    chk("x0_wen",      32'(rf_wen), 32'd0);
    chk("x0_misalign", 32'(misalign_err), 32'd0);
    chk("x0_cnt",      retire_cnt, 32'd11);

    // Contention after reset: LSU, EXU, LSU, EXU
    rst = 1'b1; tick(); rst = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h11;
    load(5'd2, 2'b10, 2'd0, 1'b0); lsu_rdata = 32'h22222222;
    #1;
    chk("c0_lsu_rdy", 32'(lsu_ready), 32'd1);
    chk("c0_exu_rdy", 32'(exu_ready), 32'd0);
    tick();
    chk("c1_waddr", 32'(rf_waddr), 32'd2);
    chk("c1_wdata", rf_wdata, 32'h22222222);
    chk("c1_exu_rdy", 32'(exu_ready), 32'd1);
    chk("c1_lsu_rdy", 32'(lsu_ready), 32'd0);
    lsu_rdata = 32'h33333333;
    tick();
    chk("c2_wen",   32'(rf_wen), 32'd1);
    chk("c2_waddr", 32'(rf_waddr), 32'd1);
    chk("c2_wdata", rf_wdata, 32'h11);
    exu_data = 32'h44;
    tick();
    chk("c3_waddr", 32'(rf_waddr), 32'd2);
    chk("c3_wdata", rf_wdata, 32'h33333333);
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    chk("c4_wen",   32'(rf_wen), 32'd1);
    chk("c4_waddr", 32'(rf_waddr), 32'd1);
    chk("c4_wdata", rf_wdata, 32'h44);
    chk("c4_cnt",   retire_cnt, 32'd4);

    // Reset right after an accept
    exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h66; tick();
    chk("r0_wen", 32'(rf_wen), 32'd1);
    chk("r0_cnt", retire_cnt, 32'd5);
    rst = 1'b1; lsu_valid = 1'b1;
    #1;
    chk("r_exu_rdy", 32'(exu_ready), 32'd0);
    chk("r_lsu_rdy", 32'(lsu_ready), 32'd0);
    tick();
    chk("r_wen",   32'(rf_wen), 32'd0);
    chk("r_cnt",   retire_cnt, 32'd0);
    chk("r_waddr", 32'(rf_waddr), 32'd0);
    rst = 1'b0; lsu_valid = 1'b0; tick();
    exu_valid = 1'b0;
    chk("rr_wen",   32'(rf_wen), 32'd1);
    chk("rr_waddr", 32'(rf_waddr), 32'd6);
    chk("rr_cnt",   retire_cnt, 32'd1);

`ifdef WB_FORWARD_EN
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'hDEAD; tick();
    exu_valid = 1'b0;
    fwd_raddr = 5'd7; fwd_rf_data = 32'h1;
    #1 chk("fwd_hit", fwd_data, 32'hDEAD);
    fwd_raddr = 5'd0;
    #1 chk("fwd_x0", fwd_data, 32'h1);
    fwd_raddr = 5'd6;
    #1 chk("fwd_miss", fwd_data, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
